// File: rtl/myrv_pkg.sv
// Shared types and constants for the myrv core sequencer.
//   seq_state_t : sequencer FSM states (7 states)
//   WSEL_*      : register-file write-data source select codes
package myrv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } seq_state_t;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC4 = 2'd2;

endpackage

// File: rtl/mem_watchdog.sv
// Memory wait watchdog.
// Counts cycles a memory request has been waiting for ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the counter (takes priority over count_en)
//   count_en   : advance the counter by one this cycle
//   expired    : counter has reached TIMEOUT_CYC-1
// Parameter TIMEOUT_CYC (>= 2): wait-cycle limit.
module mem_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the myrv core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port and
// drives the IR/PC/regfile enables; one instruction in flight.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   run                        : 1 = start/continue issuing instructions
//   dec_mem, dec_mem_read      : load/store, 1 = load
//   dec_branch, dec_uncond     : branch, unconditional jump
//   dec_wb                     : non-load instruction writes rd
//   cmp_true                   : ALU compare result (valid in EXECUTE)
//   mem_ready                  : memory accepts/completes transfer
//   mem_valid, mem_we          : memory request, 1 = store
//   mem_addr_sel               : 0 = PC, 1 = ALU result
//   ir_load, pc_load           : IR latch, PC update
//   pc_sel_tgt                 : 1 = branch target, 0 = PC+4
//   rf_we, rf_wsel             : regfile write enable / source
//   retire                     : one pulse per completed instruction
//   bus_err                    : sticky memory timeout
//   cycle_cnt, instret_cnt     : perf counters
//   dbg_state                  : current FSM state
// Build option: define MYRV_SEQ_PERF_EN to implement the perf counters;
// otherwise they read as zero and no counter flops exist.
//
// Memory handshake: a transfer completes on a cycle where mem_valid and
// mem_ready are both high. Once mem_valid rises, mem_valid, mem_we and
// mem_addr_sel stay constant until that cycle; the only other exit is the
// watchdog timeout, which moves to HALT and drops the request.
module core_sequencer
  import myrv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             dec_mem,
  input  logic             dec_mem_read,
  input  logic             dec_branch,
  input  logic             dec_uncond,
  input  logic             dec_wb,
  input  logic             cmp_true,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_sel_tgt,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic             retire,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output seq_state_t       dbg_state
);

  seq_state_t state_q, state_d;
  logic       taken_q;
  logic       wd_clear, wd_count_en, wd_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch decision is captured while the compare result is valid and
  // consumed in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q <= 1'b0;
    end else if (state_q == ST_EXECUTE) begin
      taken_q <= dec_uncond | (dec_branch & cmp_true);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_valid    = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_sel_tgt   = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = WSEL_ALU;
    retire       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (wd_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = dec_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_valid    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = ~dec_mem_read;
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (wd_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        pc_load    = 1'b1;
        pc_sel_tgt = taken_q;
        rf_we      = dec_mem ? dec_mem_read : dec_wb;
        if (dec_mem && dec_mem_read) rf_wsel = WSEL_MEM;
        else if (dec_uncond)         rf_wsel = WSEL_PC4;
        else                         rf_wsel = WSEL_ALU;
        retire     = 1'b1;
        state_d    = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear on entry to a memory phase; count only while actually waiting.
  assign wd_clear    = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEM));
  assign wd_count_en = ((state_q == ST_FETCH) || (state_q == ST_MEM)) &&
                       !mem_ready && !wd_expired;

  mem_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  // HALT is only reachable through a timeout, so it doubles as the flag.
  assign bus_err   = (state_q == ST_HALT);
  assign dbg_state = state_q;

`ifdef MYRV_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (state_q != ST_HALT)) cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. Each cycle's expected output vector is
// derived from the instruction's phase sequence (fetch waits, decode,
// execute, memory waits, writeback) and queued with its stimulus.
module tb_core_sequencer;
  import myrv_pkg::*;

  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 32;
  localparam int VW          = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             dec_mem = 1'b0, dec_mem_read = 1'b0, dec_branch = 1'b0;
  logic             dec_uncond = 1'b0, dec_wb = 1'b0, cmp_true = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_valid, mem_we, mem_addr_sel, ir_load, pc_load;
  logic             pc_sel_tgt, rf_we, retire, bus_err;
  logic [1:0]       rf_wsel;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  seq_state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus: {ready, run, dec = {mem, rd, br, unc, wb, cmp}}
  typedef struct packed {
    logic       rdy;
    logic       run;
    logic [5:0] dec;
  } stim_t;

  logic [VW-1:0] exp_q[$];
  stim_t         stim_q[$];

  core_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .dec_mem(dec_mem), .dec_mem_read(dec_mem_read), .dec_branch(dec_branch),
    .dec_uncond(dec_uncond), .dec_wb(dec_wb), .cmp_true(cmp_true),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_load(pc_load),
    .pc_sel_tgt(pc_sel_tgt), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .retire(retire), .bus_err(bus_err), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [VW-1:0] observed();
    return {mem_valid, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel_tgt,
            rf_we, rf_wsel, retire, bus_err};
  endfunction

  function automatic logic [VW-1:0] fetch_vec(input logic done);
    return {1'b1, 1'b0, 1'b0, done, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
  endfunction

  function automatic logic [VW-1:0] mem_vec(input logic is_store);
    return {1'b1, is_store, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
  endfunction

  function automatic logic [VW-1:0] wb_vec(input logic [5:0] d);
    logic mem, rd, br, unc, wb, cmp, taken, we;
    logic [1:0] wsel;
    {mem, rd, br, unc, wb, cmp} = d;
    taken = unc | (br & cmp);
    we    = mem ? rd : wb;
    wsel  = (mem && rd) ? 2'd1 : (unc ? 2'd2 : 2'd0);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, taken, we, wsel, 1'b1, 1'b0};
  endfunction

  task automatic push_cyc(input logic [VW-1:0] e, input logic rdy,
                          input logic r, input logic [5:0] d);
    stim_t s;
    s.rdy = rdy; s.run = r; s.dec = d;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Queue one instruction with f fetch waits and m memory waits.
  // last=1 drops run for the whole instruction so the core idles after it.
  task automatic push_instr(input logic [5:0] d, input int f, input int m,
                            input bit last);
    logic r;
    r = !last;
    for (int i = 0; i <= f; i++) push_cyc(fetch_vec(i == f), (i == f), r, d);
    push_cyc('0, 1'($urandom), r, d);
    push_cyc('0, 1'($urandom), r, d);
    if (d[5]) begin
      for (int i = 0; i <= m; i++) push_cyc(mem_vec(!d[4]), (i == m), r, d);
    end
    push_cyc(wb_vec(d), 1'($urandom), r, d);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cyc('0, 1'($urandom), 1'b0, 6'd0);
  endtask

  // Plays the queued stimulus and compares each cycle at the falling edge.
  task automatic drain(input string name);
    stim_t s;
    logic [VW-1:0] e, o;
    int cyc;
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_ready = s.rdy;
      run       = s.run;
      {dec_mem, dec_mem_read, dec_branch, dec_uncond, dec_wb, cmp_true} = s.dec;
      @(negedge clk);
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %b expected %b", name, cyc, o, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // From IDLE at posedge+1: raise run so the next cycle is FETCH.
  task automatic start_run();
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] rand_dec();
    logic c;
    c = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       return {5'b00001, c};          // ALU op
      1:       return {5'b11000, c};          // load
      2:       return {5'b10000, c};          // store
      3:       return {5'b00100, c};          // conditional branch
      4:       return {5'b00011, c};          // jump and link
      default: return 6'($urandom);           // arbitrary decode bits
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (observed() !== '0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs %b state %0d, required 0 and IDLE",
                 i, observed(), dbg_state);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (cycle_cnt !== '0 || instret_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: cycle %0d instret %0d, required 0", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_alu();
    start_run();
    push_instr(6'b000010, 0, 0, 1'b1);    // ADD
    push_idle(2);
    drain("alu_add");
  endtask

  task automatic test_load_wait();
    start_run();
    push_instr(6'b110000, 0, 3, 1'b1);    // load, ready after 3 waits
    push_idle(2);
    drain("load_wait");
  endtask

  task automatic test_branch();
    start_run();
    push_instr(6'b001001, 0, 0, 1'b0);    // BEQ taken
    push_instr(6'b001000, 1, 0, 1'b0);    // BEQ not taken
    push_instr(6'b000110, 0, 0, 1'b1);    // JAL
    push_idle(2);
    drain("branch_jal");
  endtask

  // Ready arriving on the last permitted wait cycle must not raise an error.
  task automatic test_timeout_edge();
    start_run();
    push_instr(6'b000010, TIMEOUT_CYC - 1, 0, 1'b0);
    push_instr(6'b100000, 0, TIMEOUT_CYC - 1, 1'b1);
    push_idle(2);
    drain("timeout_edge");
  endtask

  task automatic test_back_to_back();
    start_run();
    for (int n = 0; n < 40; n++) begin
      push_instr(rand_dec(), $urandom_range(0, TIMEOUT_CYC - 1),
                 $urandom_range(0, TIMEOUT_CYC - 1), n == 39);
    end
    push_idle(3);
    drain("back_to_back");
  endtask

  task automatic test_async_reset();
    start_run();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: mem_valid got %b expected 1", mem_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs got %b expected 0", observed());
    end
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_post: outputs %b state %0d, required 0 and IDLE", observed(), dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    start_run();
    for (int i = 0; i < TIMEOUT_CYC; i++) push_cyc(fetch_vec(1'b0), 1'b0, 1'b1, 6'b000010);
    for (int i = 0; i < 6; i++) push_cyc(11'b1, 1'($urandom), 1'($urandom), 6'($urandom));
    drain("timeout_halt");
    checks++;
    if (dbg_state !== ST_HALT) begin
      errors++;
      $display("FAIL timeout_state: state %0d expected HALT", dbg_state);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL timeout_cleared: outputs got %b expected 0", observed());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_perf();
    do_reset();
    start_run();
    push_instr(6'b000010, 0, 0, 1'b0);
    push_instr(6'b000010, 0, 0, 1'b0);
    push_instr(6'b000010, 0, 0, 1'b1);
    push_idle(3);
    drain("perf_traffic");
    checks++;
`ifdef MYRV_SEQ_PERF_EN
    if (instret_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
      errors++;
      $display("FAIL perf_counts: instret %0d cycle %0d, required 3 and 12", instret_cnt, cycle_cnt);
    end
`else
    if (instret_cnt !== '0 || cycle_cnt !== '0) begin
      errors++;
      $display("FAIL perf_disabled: instret %0d cycle %0d, required 0 and 0", instret_cnt, cycle_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_timeout_edge();
    test_back_to_back();
    test_async_reset();
    test_timeout();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so a stuck run still terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
